// File: rtl/ad7606_emu.sv
// ad7606_emu: AD7606-style parallel ADC emulator producing synthetic sample patterns.
// Async strobes are synchronized; conversion timing scales with the oversampling ratio.
module ad7606_emu #(
  parameter int NUM_CH = 8,
  parameter int DW = 16,
  parameter int TCONV = 200
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          convst_i,
  input  logic          cs_n_i,
  input  logic          rd_n_i,
  input  logic [2:0]    os_i,
  input  logic [1:0]    mode_i,
  output logic [DW-1:0] db_o,
  output logic          db_oe_o,
  output logic          busy_o,
  output logic          frstdata_o,
  output logic          overrun_o,
  output logic          os_err_o
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [31:0] SEED = 32'hACE1ACE1;
  localparam logic [31:0] TAPS = 32'h80200003;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  state_t r_state, w_next;
  logic [2:0] r_cv, r_rd;
  logic [1:0] r_cs;
  logic [31:0] r_cnt, r_lfsr, r_conv_idx, w_lfsr_nxt, w_cnt0;
  logic [CW-1:0] r_ld, r_ptr;
  logic [DW-1:0] r_chan [NUM_CH];
  logic [DW-1:0] r_db, w_val;
  logic r_frst, r_ovr, r_oserr;
  logic w_cv_edge, w_rd_ok, w_start, w_ld_last;
  // sync stage 2 is bit 1, history is bit 2
  assign w_cv_edge = r_cv[1] & ~r_cv[2];
  assign w_rd_ok = ~r_rd[1] & r_rd[2] & ~r_cs[1];
  assign w_start = w_cv_edge && r_state == IDLE && os_i != 3'b111;
  assign w_ld_last = r_ld == CW'(NUM_CH - 1);
  assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 32'd0);
  assign w_cnt0 = (32'(TCONV) << os_i) - 32'(NUM_CH + 1);
  assign w_val = mode_i == 2'b01 ? DW'(r_conv_idx + 32'(r_ld)) :
                 mode_i == 2'b10 ? DW'(r_ld) : r_lfsr[DW-1:0];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? CONV : IDLE;
      CONV:    w_next = r_cnt == 32'd0 ? LOAD : CONV;
      LOAD:    w_next = w_ld_last ? IDLE : LOAD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cv <= '0;
      r_rd <= '1;
      r_cs <= '1;
      r_cnt <= '0;
      r_lfsr <= SEED;
      r_conv_idx <= '0;
      r_ld <= '0;
      r_ptr <= '0;
      r_db <= '0;
      r_frst <= 1'b0;
      r_ovr <= 1'b0;
      r_oserr <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_chan[i] <= '0;
    end else begin
      r_cv <= {r_cv[1:0], convst_i};
      r_rd <= {r_rd[1:0], rd_n_i};
      r_cs <= {r_cs[0], cs_n_i};
      if (w_start) r_cnt <= w_cnt0;
      else if (r_state == CONV) r_cnt <= r_cnt - 32'd1;
      if (w_cv_edge && r_state != IDLE) r_ovr <= 1'b1;
      if (w_cv_edge && r_state == IDLE && os_i == 3'b111) r_oserr <= 1'b1;
      if (w_rd_ok) begin
        r_db <= r_chan[r_ptr];
        r_frst <= r_ptr == '0;
        r_ptr <= r_ptr == CW'(NUM_CH - 1) ? '0 : r_ptr + 1'b1;
      end
      if (r_state == LOAD) begin
        r_chan[r_ld] <= w_val;
        r_ld <= w_ld_last ? '0 : r_ld + 1'b1;
        if (mode_i == 2'b00 || mode_i == 2'b11) r_lfsr <= w_lfsr_nxt;
        if (w_ld_last) begin
          r_ptr <= '0;
          r_conv_idx <= r_conv_idx + 32'd1;
        end
      end
    end
  end
  assign busy_o = r_state != IDLE;
  assign db_oe_o = ~r_cs[1];
  assign db_o = db_oe_o ? r_db : 'z;
  assign frstdata_o = db_oe_o ? r_frst : 1'bz;
  assign overrun_o = r_ovr;
  assign os_err_o = r_oserr;
endmodule

// File: tb/tb_ad7606_emu.sv
// tb_ad7606_emu: directed bench for ad7606_emu with a cycle-level behavioural model.
module tb_ad7606_emu;
  logic clk = 1'b0, reset_i = 1'b1, convst_i = 1'b0, cs_n_i = 1'b1, rd_n_i = 1'b1;
  logic [2:0] os_i = 3'd0;
  logic [1:0] mode_i = 2'b10;
  wire [15:0] db_o;
  wire frstdata_o;
  logic db_oe_o, busy_o, overrun_o, os_err_o;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  ad7606_emu dut (
    .clk_i(clk), .reset_i(reset_i), .convst_i(convst_i), .cs_n_i(cs_n_i), .rd_n_i(rd_n_i),
    .os_i(os_i), .mode_i(mode_i), .db_o(db_o), .db_oe_o(db_oe_o), .busy_o(busy_o),
    .frstdata_o(frstdata_o), .overrun_o(overrun_o), .os_err_o(os_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: inputs sampled at edge n act at edge n+2; busy lasts 200<<os cycles;
  // the new channel set becomes visible when busy ends.
  int m_left = 0, m_ptr = 0;
  logic [15:0] m_chan [8];
  logic [31:0] m_lfsr = 32'hACE1ACE1, m_idx = 0;
  logic [15:0] m_db = 0;
  logic m_frst = 0, m_oe = 0, m_ovr = 0, m_oserr = 0;
  logic [2:0] q_cv = 3'b000, q_cs = 3'b111, q_rd = 3'b111;
  logic cv_e, rd_f, cs_lo, was_busy;

  initial for (int i = 0; i < 8; i++) m_chan[i] = 0;

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_left = 0; m_ptr = 0; m_lfsr = 32'hACE1ACE1; m_idx = 0; m_db = 0;
      m_frst = 0; m_oe = 0; m_ovr = 0; m_oserr = 0;
      q_cv = 3'b000; q_cs = 3'b111; q_rd = 3'b111;
      for (int i = 0; i < 8; i++) m_chan[i] = 0;
    end else begin
      cv_e = q_cv[1] & ~q_cv[2];
      rd_f = ~q_rd[1] & q_rd[2];
      cs_lo = ~q_cs[1];
      was_busy = m_left > 0;
      if (rd_f && cs_lo) begin
        m_db = m_chan[m_ptr];
        m_frst = m_ptr == 0;
        m_ptr = (m_ptr + 1) % 8;
      end
      if (was_busy) begin
        m_left--;
        if (m_left == 0) begin
          for (int c = 0; c < 8; c++) begin
            if (mode_i == 2'b01) m_chan[c] = 16'(m_idx + 32'(c));
            else if (mode_i == 2'b10) m_chan[c] = 16'(c);
            else begin
              m_chan[c] = m_lfsr[15:0];
              m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'd0);
            end
          end
          m_idx++;
          m_ptr = 0;
        end
      end
      if (cv_e) begin
        if (was_busy) m_ovr = 1;
        else if (os_i == 3'b111) m_oserr = 1;
        else m_left = 200 << os_i;
      end
      q_cv = {q_cv[1:0], convst_i};
      q_cs = {q_cs[1:0], cs_n_i};
      q_rd = {q_rd[1:0], rd_n_i};
      m_oe = ~q_cs[1];
    end
  end

  always @(negedge clk) begin
    chk("busy", busy_o, m_left > 0);
    chk("db_oe", db_oe_o, m_oe);
    chk("overrun", overrun_o, m_ovr);
    chk("os_err", os_err_o, m_oserr);
    if (m_oe) begin
      chk("db", db_o, m_db);
      chk("frstdata", frstdata_o, m_frst);
    end
  end

  task automatic rd_cycle(output logic [15:0] d, output logic f);
    @(negedge clk); rd_n_i = 0;
    repeat (4) @(negedge clk);
    d = db_o; f = frstdata_o; rd_n_i = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_conv(input int extra, output int w);
    int t;
    w = 0;
    @(negedge clk); convst_i = 1;
    for (t = 0; t < 6000; t++) begin
      @(negedge clk);
      if (t == 2) convst_i = 0;
      if (extra >= 0 && t == extra) convst_i = 1;
      if (extra >= 0 && t == extra + 3) convst_i = 0;
      if (busy_o) w++;
      else if (w > 0) break;
    end
    if (t == 6000) begin
      n_chk++; n_err++;
      $display("FAIL conv_timeout: busy never completed, width so far %0d", w);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int lim);
    int t;
    for (t = 0; t < lim && busy_o !== lvl; t++) @(negedge clk);
    if (t == lim) begin
      n_chk++; n_err++;
      $display("FAIL busy_wait: busy_o %0b never reached %0b", busy_o, lvl);
    end
  endtask

  initial begin
    int w;
    logic [15:0] d;
    logic f;
    repeat (3) @(negedge clk);
    reset_i = 0;
    chk("reset_busy", busy_o, 0);
    chk("reset_oe", db_oe_o, 0);
    chk("reset_flags", {overrun_o, os_err_o}, 0);
    // basic conversion, channel-index pattern, pointer wrap on 9th read
    run_conv(-1, w);
    chk("width_os0", w, 200);
    cs_n_i = 0; repeat (4) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      rd_cycle(d, f);
      chk("t1_data", d, i % 8);
      chk("t1_frst", f, (i % 8) == 0);
    end
    // reads with cs high must not move the pointer
    run_conv(-1, w);
    cs_n_i = 1; repeat (4) @(negedge clk);
    chk("cs_hi_oe", db_oe_o, 0);
    repeat (3) rd_cycle(d, f);
    cs_n_i = 0; repeat (4) @(negedge clk);
    rd_cycle(d, f);
    chk("after_cs_data", d, 0);
    chk("after_cs_frst", f, 1);
    // second convst 50 cycles into busy
    run_conv(52, w);
    chk("width_overrun", w, 200);
    chk("overrun_set", overrun_o, 1);
    w = 0;
    repeat (300) begin @(negedge clk); if (busy_o) w++; end
    chk("single_conv", w, 0);
    // illegal oversampling
    os_i = 3'b111;
    @(negedge clk); convst_i = 1;
    repeat (3) @(negedge clk); convst_i = 0;
    w = 0;
    repeat (20) begin @(negedge clk); if (busy_o) w++; end
    chk("oserr_set", os_err_o, 1);
    chk("oserr_nobusy", w, 0);
    os_i = 3'b000;
    rd_cycle(d, f); chk("oserr_ch0", d, 0); chk("oserr_f0", f, 1);
    rd_cycle(d, f); chk("oserr_ch1", d, 1); chk("oserr_f1", f, 0);
    // reads during a conversion see the previous set
    run_conv(-1, w);
    mode_i = 2'b01;
    @(negedge clk); convst_i = 1;
    repeat (3) @(negedge clk); convst_i = 0;
    wait_busy(1, 20);
    for (int i = 0; i < 8; i++) begin
      rd_cycle(d, f);
      chk("busy_rd_data", d, i);
      chk("busy_rd_frst", f, i == 0);
    end
    wait_busy(0, 300);
    rd_cycle(d, f);
    chk("ramp_ch0", d, 4);
    // reset mid-conversion
    @(negedge clk); convst_i = 1;
    repeat (3) @(negedge clk); convst_i = 0;
    wait_busy(1, 20);
    repeat (100) @(negedge clk);
    #2 reset_i = 1;
    #1 chk("abort_busy", busy_o, 0);
    repeat (3) @(negedge clk);
    reset_i = 0;
    repeat (4) @(negedge clk);
    rd_cycle(d, f);
    chk("abort_data", d, 0);
    chk("abort_frst", f, 1);
    // oversampling x8, ramp, back to back
    os_i = 3'b011;
    run_conv(-1, w); chk("width_os3_a", w, 1600);
    run_conv(-1, w); chk("width_os3_b", w, 1600);
    for (int i = 0; i < 8; i++) begin
      rd_cycle(d, f);
      chk("os3_data", d, i + 1);
      chk("os3_frst", f, i == 0);
    end
    // LFSR pattern from seed
    @(negedge clk); #2 reset_i = 1;
    repeat (2) @(negedge clk);
    reset_i = 0; os_i = 3'b000; mode_i = 2'b00;
    repeat (4) @(negedge clk);
    run_conv(-1, w);
    rd_cycle(d, f); chk("lfsr_ch0", d, 16'hACE1); chk("lfsr_f0", f, 1);
    rd_cycle(d, f); chk("lfsr_ch1", d, 16'hD673); chk("lfsr_f1", f, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ad7606_emu.md
AD7606_EMU -- requirements
Module: ad7606_emu

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of emulated channels (2..16).
REQ-002 SHALL have parameter DW, default 16, sample word width (8..32).
REQ-003 SHALL have parameter TCONV, default 200, base conversion time in clk_i cycles (TCONV >= NUM_CH+2).
REQ-004 SHALL have port clk_i  in  1  system clock.
REQ-005 SHALL have port reset_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port convst_i  in  1  conversion start, rising-edge active, asynchronous to clk_i.
REQ-007 SHALL have port cs_n_i  in  1  chip select, active-low, asynchronous.
REQ-008 SHALL have port rd_n_i  in  1  read strobe, falling-edge active, asynchronous.
REQ-009 SHALL have port os_i  in  3  oversampling select, sampled at the detected convst edge.
REQ-010 SHALL have port mode_i  in  2  data pattern: 00 LFSR, 01 ramp, 10 channel index, 11 treated as 00.
REQ-011 SHALL have port db_o  out  DW  parallel data word.
REQ-012 SHALL have port db_oe_o  out  1  data drive enable, equal to the synchronized inverse of cs_n_i; db_o and frstdata_o are undriven when 0.
REQ-013 SHALL have port busy_o  out  1  conversion in progress.
REQ-014 SHALL have port frstdata_o  out  1  high while db_o holds channel 0.
REQ-015 SHALL have port overrun_o  out  1  sticky: convst edge received while busy.
REQ-016 SHALL have port os_err_o  out  1  sticky: conversion requested with os_i = 111.

Function
REQ-017 SHALL pass convst_i, cs_n_i and rd_n_i each through a 2-flop synchronizer plus a history flop; edges are detected from stage 2 vs history.
REQ-018 SHALL implement FSM IDLE -> CONV -> LOAD -> IDLE.
REQ-019 On a convst rising edge in IDLE with os_i != 111: SHALL latch os_i, enter CONV, assert busy_o registered on the detection edge, i.e. the 3rd clk_i edge after convst_i is first sampled high.
REQ-020 Total busy_o high time SHALL be exactly (TCONV << os) cycles; CONV occupies the first (TCONV << os) - NUM_CH cycles, LOAD the last NUM_CH cycles.
REQ-021 In LOAD, SHALL write one channel register per cycle, channel 0 first.
REQ-022 Mode 00 SHALL use a 32-bit Galois LFSR (taps 32,22,2,1; seed 0xACE1ACE1), stepped once per LOAD cycle; the channel value is the low DW bits before stepping.
REQ-023 Mode 01 SHALL load (conv_idx + ch) mod 2^DW; conv_idx is a 32-bit count of completed conversions, starting at 0, incremented as busy_o falls.
REQ-024 Mode 10 SHALL load ch, zero-extended to DW.
REQ-025 At the LOAD -> IDLE transition, SHALL deassert busy_o and reset the read pointer to 0.
REQ-026 A convst edge in CONV or LOAD SHALL be ignored and SHALL set overrun_o.
REQ-027 A convst edge with os_i = 111 SHALL set os_err_o and leave the FSM in IDLE, with busy_o kept low.
REQ-028 On an rd falling edge with synchronized cs low, SHALL register db_o = chan[ptr] and frstdata_o = (ptr == 0) on the detection edge, then increment ptr.
REQ-029 ptr SHALL wrap from NUM_CH-1 to 0, so the (NUM_CH+1)th read returns channel 0 again with frstdata_o = 1.
REQ-030 Reads during busy_o SHALL return the previous completed data set; channel registers change only in LOAD.
REQ-031 rd edges while cs is high SHALL be ignored and SHALL NOT advance ptr.
REQ-032 Simultaneous convst and rd edges in IDLE SHALL both be serviced in the same cycle.

Reset
REQ-033 While reset_i = 1: FSM in IDLE; busy_o, frstdata_o, overrun_o, os_err_o, db_oe_o = 0; db_o, all channel registers, ptr and conv_idx = 0; LFSR = seed; synchronizers and history flops = 1 for cs/rd and 0 for convst.
REQ-034 Reset asserted mid-conversion SHALL abort it; busy_o falls asynchronously and no data is loaded.
REQ-035 Sticky flags SHALL clear only on reset.

Verification
REQ-036 Defaults, os = 000, mode = 10: one convst pulse -> busy_o high exactly 200 cycles; 8 reads return 0..7 with frstdata_o only on the first; a 9th read returns 0 with frstdata_o = 1.
REQ-037 os = 011, mode = 01: two back-to-back conversions -> busy_o high 1600 cycles each; the second set reads 1..8.
REQ-038 convst pulse 50 cycles into busy -> overrun_o = 1, busy_o width unchanged, one conversion only.
REQ-039 os = 111 -> os_err_o = 1, busy_o stays 0, channel data unchanged.
REQ-040 Reads during the second conversion (mode 10 then mode 01) -> values 0..7 from the first set; reset_i at cycle 100 of busy -> busy_o = 0 immediately, reads return 0.
REQ-041 cs_n_i = 1 while toggling rd_n_i -> db_oe_o = 0 and ptr unchanged; the subsequent read with cs low returns channel 0.
